// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master: optional START, one byte written or read, optional STOP.
// Define I2C_ACK_CHECK_EN to report slave NACKs on ack_err and force a STOP after them.
module i2c_byte_ctrl #(
    parameter int SYS_CLK_HZ = 50_000_000,
    parameter int I2C_HZ     = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [3:0] cmd,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       done,
    output logic       busy,
    output logic       ack_err,
    output logic       scl,
    output logic       sda_out,
    output logic       sda_oe,
    input  logic       sda_in
);
    localparam int P  = SYS_CLK_HZ / I2C_HZ;
    localparam int CW = $clog2(P);
    localparam logic [CW-1:0] Q1_C   = CW'(P / 4);
    localparam logic [CW-1:0] H_C    = CW'(P / 2);
    localparam logic [CW-1:0] Q3_C   = CW'((3 * P) / 4);
    localparam logic [CW-1:0] LAST_C = CW'(P - 1);

    typedef enum logic [2:0] {IDLE, START, WRITE, RACK, READ, SACK, STOP, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_cnt;
    logic [3:0]      cmd_q;
    logic [7:0]      wr_q;
    logic [6:0]      rd_sh;
    logic            sda_q;
    logic            nack_stop;
    logic            period_end;
    logic            hold_zero;

    assign period_end = (cnt == LAST_C);
    // An empty command lingers one extra cycle in DONE so done lands two cycles after req.
    assign hold_zero  = (cmd_q == 4'd0) && (cnt == '0);

    function automatic state_t seg_after_start(input logic [3:0] c);
        if (c[1])      return WRITE;
        else if (c[2]) return READ;
        else if (c[3]) return STOP;
        else           return DONE;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (req) state_nx = cmd[0] ? START : seg_after_start(cmd);
            START: if (period_end) state_nx = seg_after_start(cmd_q);
            WRITE: if (period_end && bit_cnt == 3'd7) state_nx = RACK;
            RACK:  if (period_end) state_nx = (cmd_q[3] || nack_stop) ? STOP : DONE;
            READ:  if (period_end && bit_cnt == 3'd7) state_nx = SACK;
            SACK:  if (period_end) state_nx = cmd_q[3] ? STOP : DONE;
            STOP:  if (period_end) state_nx = DONE;
            DONE:  state_nx = hold_zero ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_cnt <= 3'd0;
            cmd_q   <= 4'd0;
            wr_q    <= 8'd0;
            rd_sh   <= 7'd0;
            rd_data <= 8'd0;
            sda_q   <= 1'b1;
        end else if (state == IDLE) begin
            cnt     <= '0;
            bit_cnt <= 3'd0;
            if (req) begin
                cmd_q <= cmd;
                wr_q  <= wr_data;
            end
        end else if (state == DONE) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= period_end ? '0 : cnt + CW'(1);
            if ((state == WRITE || state == READ) && period_end)
                bit_cnt <= bit_cnt + 3'd1;
            if (state == WRITE && cnt == Q1_C)
                sda_q <= wr_q[3'd7 - bit_cnt];
            if (state == READ && cnt == Q3_C) begin
                rd_sh <= {rd_sh[5:0], sda_in};
                if (bit_cnt == 3'd7)
                    rd_data <= {rd_sh, sda_in};
            end
        end
    end

`ifdef I2C_ACK_CHECK_EN
    logic nack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         nack_q <= 1'b0;
        else if (state == IDLE && req)      nack_q <= 1'b0;
        else if (state == RACK && cnt == Q3_C) nack_q <= sda_in;
    end

    assign nack_stop = nack_q;
`else
    assign nack_stop = 1'b0;
`endif

    always_comb begin
        scl     = 1'b1;
        sda_out = 1'b1;
        sda_oe  = 1'b0;
        done    = 1'b0;
        ack_err = 1'b0;
        busy    = (state != IDLE);
        case (state)
            START: begin
                scl     = (cnt < Q3_C);
                sda_out = (cnt < H_C);
                sda_oe  = 1'b1;
            end
            WRITE: begin
                scl     = (cnt >= H_C);
                sda_out = sda_q;
                sda_oe  = 1'b1;
            end
            RACK, READ: begin
                scl = (cnt >= H_C);
            end
            SACK: begin
                scl     = (cnt >= H_C);
                sda_out = cmd_q[3];
                sda_oe  = 1'b1;
            end
            STOP: begin
                scl     = (cnt >= Q1_C);
                sda_out = (cnt >= Q3_C);
                sda_oe  = 1'b1;
            end
            DONE: begin
                done    = !hold_zero;
                ack_err = !hold_zero && nack_stop;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Directed bench for i2c_byte_ctrl at P=40 with a behavioural slave and a bus monitor.
module tb_i2c_byte_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic [7:0] wr_data = 8'd0;
    logic [7:0] rd_data;
    logic       done, busy, ack_err, scl, sda_out, sda_oe;
    logic       sda_line, slv_sda;

    always #5 clk = ~clk;

    i2c_byte_ctrl #(.SYS_CLK_HZ(4_000_000), .I2C_HZ(100_000)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .wr_data(wr_data),
        .rd_data(rd_data), .done(done), .busy(busy), .ack_err(ack_err),
        .scl(scl), .sda_out(sda_out), .sda_oe(sda_oe), .sda_in(sda_line)
    );

    typedef struct {
        int         lat;
        logic [7:0] rd;
        logic       aerr;
        logic       start;
        logic       stop;
        logic       act;
        logic [8:0] bits;
        int         edges;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    // Slave: 0 released, 1 acknowledges a written byte with sack, 2 returns sbyte.
    int         smode = 0;
    logic [7:0] sbyte = 8'd0;
    logic       sack = 1'b0;

    logic       clr = 1'b0;
    logic       scl_d = 1'b1, sda_d = 1'b1;
    logic       start_seen = 1'b0, stop_seen = 1'b0, bus_act = 1'b0;
    logic [8:0] cap = 9'd0;
    int         redges = 0, falls = 0, done_cnt = 0;

    always_comb begin
        slv_sda = 1'b1;
        if (smode == 2 && falls >= 1 && falls <= 8) slv_sda = sbyte[8 - falls];
        else if (smode == 1 && falls == 9)         slv_sda = sack;
    end
    assign sda_line = sda_oe ? sda_out : slv_sda;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        scl_d <= scl;
        sda_d <= sda_line;
        if (clr) begin
            redges <= 0; falls <= 0; cap <= 9'd0; done_cnt <= 0;
            start_seen <= 1'b0; stop_seen <= 1'b0; bus_act <= 1'b0;
        end else begin
            if (scl && !scl_d) begin
                if (redges < 9) cap <= {cap[7:0], sda_line};
                redges <= redges + 1;
            end
            if (!scl && scl_d) falls <= falls + 1;
            if (scl && scl_d && sda_d && !sda_line) start_seen <= 1'b1;
            if (scl && scl_d && !sda_d && sda_line) stop_seen <= 1'b1;
            if (!scl || sda_oe) bus_act <= 1'b1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic [7:0] rd, input logic aerr,
                                input logic start, input logic stop, input logic act,
                                input logic [8:0] bits, input int edges);
        exp_t e;
        e.lat = lat; e.rd = rd; e.aerr = aerr; e.start = start; e.stop = stop;
        e.act = act; e.bits = bits; e.edges = edges;
        return e;
    endfunction

    task automatic run(input string name, input logic [3:0] c, input logic [7:0] wd,
                       input int mode, input logic [7:0] s_byte, input logic s_ack,
                       input exp_t e, input int extra);
        exp_t g;
        int   t0;
        bit   seen;
        smode = mode; sbyte = s_byte; sack = s_ack;
        sb.push_back(e);
        @(negedge clk);
        req = 1'b1; cmd = c; wr_data = wd; clr = 1'b1; t0 = cyc;
        @(negedge clk);
        req = 1'b0; cmd = 4'd0; clr = 1'b0;
        chk({name, "_busy_start"}, busy, 1);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
            req = (extra > 0) && (cyc - t0 == extra);
            cmd = req ? 4'b0001 : 4'd0;
        end
        req = 1'b0; cmd = 4'd0;
        chk({name, "_done_seen"}, seen, 1);
        g = sb.pop_front();
        chk({name, "_latency"}, cyc - t0, g.lat);
        chk({name, "_ack_err"}, ack_err, g.aerr);
        chk({name, "_rd_data"}, rd_data, g.rd);
        chk({name, "_start"}, start_seen, g.start);
        chk({name, "_stop"}, stop_seen, g.stop);
        chk({name, "_bus_act"}, bus_act, g.act);
        chk({name, "_sda_bits"}, cap, g.bits);
        chk({name, "_scl_edges"}, redges, g.edges);
        smode = 0;
        repeat (4) @(negedge clk);
        chk({name, "_one_done"}, done_cnt, 1);
        chk({name, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int   t0;
        exp_t e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_scl", scl, 1);
        chk("rst_sda_out", sda_out, 1);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run("wr_a0", 4'b0011, 8'hA0, 1, 8'h00, 1'b0,
            mk(401, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, {8'hA0, 1'b0}, 9), 0);
        run("rd_5a", 4'b1100, 8'h00, 2, 8'h5A, 1'b0,
            mk(401, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, {8'h5A, 1'b1}, 10), 0);
`ifdef I2C_ACK_CHECK_EN
        e = mk(401, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, {8'h3C, 1'b1}, 10);
`else
        e = mk(361, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, {8'h3C, 1'b1}, 9);
`endif
        run("wr_nack", 4'b0010, 8'h3C, 1, 8'h00, 1'b1, e, 0);
        run("rd_ack", 4'b0101, 8'h00, 2, 8'hA5, 1'b0,
            mk(401, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, {8'hA5, 1'b0}, 9), 0);
        run("wr_wins", 4'b0110, 8'h96, 1, 8'h00, 1'b0,
            mk(361, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, {8'h96, 1'b0}, 9), 0);
        run("busy_req", 4'b1011, 8'h55, 1, 8'h00, 1'b0,
            mk(441, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, {8'h55, 1'b0}, 10), 100);

        smode = 1; sack = 1'b0;
        @(negedge clk);
        req = 1'b1; cmd = 4'b0011; wr_data = 8'hC3; clr = 1'b1; t0 = cyc;
        @(negedge clk);
        req = 1'b0; cmd = 4'd0; clr = 1'b0;
        while (cyc - t0 < 150) @(negedge clk);
        chk("abort_oe_before", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_scl", scl, 1);
        chk("abort_sda_oe", sda_oe, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1; smode = 0;
        repeat (2) @(negedge clk);

        run("after_rst", 4'b1001, 8'h00, 0, 8'h00, 1'b0,
            mk(81, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 9'h000, 1), 0);
        run("nop", 4'b0000, 8'hFF, 0, 8'h00, 1'b0,
            mk(2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
